pht_ctrl: RTL and testbench

PHT_CTRL -- requirements
Module: pht_ctrl

---
 rtl/pht_ctrl.sv | 138 +++++++++++++
 tb/tb_pht_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_ctrl.sv
// pht_ctrl: single-port PHT arbiter (fetch reads, queued counter updates, clear).
// Ports: clk/reset_i, fetch req/addr/grant, update valid/addr/taken/ready,
//   flush_i, pht_op_o/pht_addr_o/pht_inc_o command, busy_o, upd_count_o.
`timescale 1ns/1ps
module pht_ctrl #(
   parameter int NUM_GHR_BITS = 5,
   parameter int UPD_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        reset_i,
   input  logic                        fetch_req_i,
   input  logic [NUM_GHR_BITS-1:0]     fetch_addr_i,
   output logic                        fetch_grant_o,
   input  logic                        update_valid_i,
   input  logic [NUM_GHR_BITS-1:0]     update_addr_i,
   input  logic                        update_taken_i,
   output logic                        update_ready_o,
   input  logic                        flush_i,
   output logic [1:0]                  pht_op_o,
   output logic [NUM_GHR_BITS-1:0]     pht_addr_o,
   output logic                        pht_inc_o,
   output logic                        busy_o,
   output logic [$clog2(UPD_DEPTH):0]  upd_count_o
);

   localparam int PW = $clog2(UPD_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(UPD_DEPTH);
   localparam logic [NUM_GHR_BITS-1:0] LAST_C = '1;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_READ = 2'b01,
      OP_UPD  = 2'b10,
      OP_CLR  = 2'b11
   } op_t;

   state_t state_q, state_d;
   logic [NUM_GHR_BITS-1:0] clr_ptr_q, clr_ptr_d;

   logic [NUM_GHR_BITS-1:0] q_addr [UPD_DEPTH];
   logic                    q_taken [UPD_DEPTH];
   logic [PW-1:0]           head_q, tail_q;
   logic [CW-1:0]           count_q;

   logic full, empty, pop, push;

   assign upd_count_o = count_q;

   always_comb begin
      full           = (count_q == FULL_C);
      empty          = (count_q == '0);
      state_d        = state_q;
      clr_ptr_d      = clr_ptr_q;
      fetch_grant_o  = 1'b0;
      update_ready_o = 1'b0;
      busy_o         = 1'b0;
      pht_op_o       = OP_NONE;
      pht_addr_o     = '0;
      pht_inc_o      = 1'b0;
      pop            = 1'b0;
      push           = 1'b0;
      unique case (state_q)
         S_CLEAR: begin
            busy_o     = 1'b1;
            pht_op_o   = OP_CLR;
            pht_addr_o = clr_ptr_q;
            clr_ptr_d  = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_C) state_d = S_IDLE;
         end
         default: begin
            update_ready_o = !full;
            // the accepted entry lands in storage at the edge, so it
            // can never be the head driven this same cycle
            push = update_valid_i && !full;
            unique case (1'b1)
               full: begin
                  pop        = 1'b1;
                  pht_op_o   = OP_UPD;
                  pht_addr_o = q_addr[head_q];
                  pht_inc_o  = q_taken[head_q];
               end
               (!full && fetch_req_i): begin
                  fetch_grant_o = 1'b1;
                  pht_op_o      = OP_READ;
                  pht_addr_o    = fetch_addr_i;
               end
               (!full && !fetch_req_i && !empty): begin
                  pop        = 1'b1;
                  pht_op_o   = OP_UPD;
                  pht_addr_o = q_addr[head_q];
                  pht_inc_o  = q_taken[head_q];
               end
               default: ;
            endcase
         end
      endcase
      // flush restarts the sweep and drops any update offered this edge;
      // the command issued this cycle still goes out
      if (flush_i) begin
         state_d   = S_CLEAR;
         clr_ptr_d = '0;
         push      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q   <= S_CLEAR;
         clr_ptr_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (pop)  head_q <= head_q + 1'b1;
            if (push) tail_q <= tail_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[tail_q]  <= update_addr_i;
         q_taken[tail_q] <= update_taken_i;
      end
   end

endmodule

// File: tb/tb_pht_ctrl.sv
// tb_pht_ctrl: directed stimulus for pht_ctrl with a queue-based reference
// model compared every cycle plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_pht_ctrl;

   localparam int NB = 5;
   localparam int DEPTH = 4;
   localparam int TBL = 1 << NB;

   logic          clk = 1'b1;
   logic          reset_i = 1'b1;
   logic          fetch_req_i = 1'b0;
   logic [NB-1:0] fetch_addr_i = '0;
   logic          fetch_grant_o;
   logic          update_valid_i = 1'b0;
   logic [NB-1:0] update_addr_i = '0;
   logic          update_taken_i = 1'b0;
   logic          update_ready_o;
   logic          flush_i = 1'b0;
   logic [1:0]    pht_op_o;
   logic [NB-1:0] pht_addr_o;
   logic          pht_inc_o;
   logic          busy_o;
   logic [2:0]    upd_count_o;

   int checks = 0;
   int errors = 0;

   pht_ctrl #(.NUM_GHR_BITS(NB), .UPD_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset_i(reset_i),
      .fetch_req_i(fetch_req_i),
      .fetch_addr_i(fetch_addr_i),
      .fetch_grant_o(fetch_grant_o),
      .update_valid_i(update_valid_i),
      .update_addr_i(update_addr_i),
      .update_taken_i(update_taken_i),
      .update_ready_o(update_ready_o),
      .flush_i(flush_i),
      .pht_op_o(pht_op_o),
      .pht_addr_o(pht_addr_o),
      .pht_inc_o(pht_inc_o),
      .busy_o(busy_o),
      .upd_count_o(upd_count_o)
   );

   always #5 clk = ~clk;

   // reference model: clear sweep as a counter, pending updates as a queue
   typedef struct {
      logic [NB-1:0] a;
      logic          t;
   } upd_t;
   upd_t mq[$];
   bit   m_valid = 0;
   bit   m_clr = 0;
   int   m_idx = 0;

   bit   e_full, e_pop, e_grant, e_ready, e_busy, e_inc;
   int   e_op, e_addr, e_cnt;

   always @(negedge clk) begin
      if (m_valid) begin
         e_full  = (mq.size() == DEPTH);
         e_pop   = 0;
         e_grant = 0;
         e_inc   = 0;
         e_op    = 0;
         e_addr  = 0;
         e_cnt   = mq.size();
         if (m_clr) begin
            e_busy  = 1;
            e_ready = 0;
            e_op    = 3;
            e_addr  = m_idx;
         end else begin
            e_busy  = 0;
            e_ready = !e_full;
            if (e_full || (!fetch_req_i && mq.size() > 0)) begin
               e_pop  = 1;
               e_op   = 2;
               e_addr = int'(mq[0].a);
               e_inc  = mq[0].t;
            end else if (fetch_req_i) begin
               e_grant = 1;
               e_op    = 1;
               e_addr  = int'(fetch_addr_i);
            end
         end
         checks++;
         if (int'(pht_op_o) !== e_op || int'(pht_addr_o) !== e_addr ||
             pht_inc_o !== e_inc || fetch_grant_o !== e_grant ||
             update_ready_o !== e_ready || busy_o !== e_busy ||
             int'(upd_count_o) !== e_cnt) begin
            errors++;
            $display("FAIL model t=%0t got op=%0d addr=%0d inc=%b gnt=%b rdy=%b busy=%b cnt=%0d want op=%0d addr=%0d inc=%0d gnt=%0d rdy=%0d busy=%0d cnt=%0d",
                     $time, pht_op_o, pht_addr_o, pht_inc_o, fetch_grant_o,
                     update_ready_o, busy_o, upd_count_o, e_op, e_addr,
                     e_inc, e_grant, e_ready, e_busy, e_cnt);
         end
      end
      // advance model to the state after the coming rising edge
      if (reset_i) begin
         m_valid = 1;
         m_clr   = 1;
         m_idx   = 0;
         mq.delete();
      end else if (m_valid) begin
         if (flush_i) begin
            m_clr = 1;
            m_idx = 0;
            mq.delete();
         end else if (m_clr) begin
            if (m_idx == TBL - 1) m_clr = 0;
            m_idx++;
         end else begin
            if (e_pop) void'(mq.pop_front());
            if (update_valid_i && !e_full)
               mq.push_back('{update_addr_i, update_taken_i});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", n, act, exp);
      end
   endtask

   task automatic run_clear();
      for (int i = 0; i < TBL; i++) begin
         chk("clr_op", int'(pht_op_o), 3);
         chk("clr_addr", int'(pht_addr_o), i);
         chk("clr_busy", int'(busy_o), 1);
         tick();
      end
   endtask

   initial begin
      // reset and full clear sweep
      tick();
      reset_i = 1'b0;
      #1;
      chk("rst_op", int'(pht_op_o), 3);
      chk("rst_addr", int'(pht_addr_o), 0);
      chk("rst_busy", int'(busy_o), 1);
      chk("rst_gnt", int'(fetch_grant_o), 0);
      chk("rst_rdy", int'(update_ready_o), 0);
      chk("rst_inc", int'(pht_inc_o), 0);
      chk("rst_cnt", int'(upd_count_o), 0);
      run_clear();
      chk("idle_busy", int'(busy_o), 0);
      chk("idle_op", int'(pht_op_o), 0);

      // fetch wins over a non-full queue
      fetch_req_i = 1'b1;
      fetch_addr_i = 5'd7;
      update_valid_i = 1'b1;
      update_addr_i = 5'd3;
      update_taken_i = 1'b1;
      #1;
      chk("f_gnt", int'(fetch_grant_o), 1);
      chk("f_op", int'(pht_op_o), 1);
      chk("f_addr", int'(pht_addr_o), 7);
      tick();
      update_valid_i = 1'b0;
      #1;
      chk("f2_op", int'(pht_op_o), 1);
      chk("f2_cnt", int'(upd_count_o), 1);
      tick();
      fetch_req_i = 1'b0;
      #1;
      chk("u_op", int'(pht_op_o), 2);
      chk("u_addr", int'(pht_addr_o), 3);
      chk("u_inc", int'(pht_inc_o), 1);
      tick();
      chk("u_done", int'(upd_count_o), 0);

      // full queue preempts fetch
      fetch_req_i = 1'b1;
      fetch_addr_i = 5'd9;
      for (int k = 0; k < 4; k++) begin
         update_valid_i = 1'b1;
         update_addr_i = 5'(10 + k);
         update_taken_i = (k % 2 == 0);
         #1;
         chk("fill_gnt", int'(fetch_grant_o), 1);
         tick();
      end
      update_valid_i = 1'b0;
      #1;
      chk("full_cnt", int'(upd_count_o), 4);
      chk("full_rdy", int'(update_ready_o), 0);
      chk("full_gnt", int'(fetch_grant_o), 0);
      chk("full_op", int'(pht_op_o), 2);
      chk("full_addr", int'(pht_addr_o), 10);
      chk("full_inc", int'(pht_inc_o), 1);
      tick();
      chk("regnt", int'(fetch_grant_o), 1);
      chk("regnt_cnt", int'(upd_count_o), 3);
      fetch_req_i = 1'b0;
      #1;
      chk("d1", int'(pht_addr_o), 11);
      chk("d1_inc", int'(pht_inc_o), 0);
      tick();
      chk("d2", int'(pht_addr_o), 12);
      tick();
      chk("d3", int'(pht_addr_o), 13);
      tick();
      chk("d_empty", int'(pht_op_o), 0);

      // accept+pop at occupancy 3, across pointer wrap
      fetch_req_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         update_valid_i = 1'b1;
         update_addr_i = 5'(20 + k);
         update_taken_i = (k != 1);
         tick();
      end
      fetch_req_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         update_addr_i = 5'(23 + k);
         update_taken_i = (k != 0);
         #1;
         chk("ap_cnt", int'(upd_count_o), 3);
         chk("ap_addr", int'(pht_addr_o), 20 + k);
         tick();
      end
      update_valid_i = 1'b0;
      chk("ap_cnt2", int'(upd_count_o), 3);
      chk("w_a23", int'(pht_addr_o), 23);
      chk("w_i23", int'(pht_inc_o), 0);
      tick();
      chk("w_a24", int'(pht_addr_o), 24);
      tick();
      chk("w_a25", int'(pht_addr_o), 25);
      chk("w_i25", int'(pht_inc_o), 1);
      tick();
      chk("w_empty", int'(upd_count_o), 0);

      // flush with two pending updates
      fetch_req_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         update_valid_i = 1'b1;
         update_addr_i = 5'(5 + k);
         tick();
      end
      update_valid_i = 1'b0;
      fetch_req_i = 1'b0;
      flush_i = 1'b1;
      #1;
      chk("fl_issue", int'(pht_op_o), 2);
      chk("fl_addr", int'(pht_addr_o), 5);
      tick();
      flush_i = 1'b0;
      update_valid_i = 1'b1;
      #1;
      chk("fl_cnt", int'(upd_count_o), 0);
      chk("fl_rdy", int'(update_ready_o), 0);
      run_clear();
      update_valid_i = 1'b0;
      #1;
      chk("fl_end_busy", int'(busy_o), 0);
      chk("fl_end_cnt", int'(upd_count_o), 0);
      chk("fl_end_op", int'(pht_op_o), 0);

      // flush re-asserted mid-clear
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("mid_addr", int'(pht_addr_o), 20);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      run_clear();
      chk("re_busy", int'(busy_o), 0);

      // reset mid-operation discards the queue
      fetch_req_i = 1'b1;
      update_valid_i = 1'b1;
      update_addr_i = 5'd17;
      tick();
      tick();
      update_valid_i = 1'b0;
      fetch_req_i = 1'b0;
      chk("pre_rst_cnt", int'(upd_count_o), 2);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      #1;
      chk("rr_cnt", int'(upd_count_o), 0);
      run_clear();
      chk("rr_op", int'(pht_op_o), 0);
      chk("rr_busy", int'(busy_o), 0);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
